// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master / three-slave bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        M1_OWN = 2'd1,
        M2_OWN = 2'd2
    } arb_state_t;

    typedef logic [1:0] slave_id_t;

    localparam slave_id_t SLV0     = 2'd0;
    localparam slave_id_t SLV1     = 2'd1;
    localparam slave_id_t SLV2     = 2'd2;
    localparam slave_id_t SLV_NONE = 2'd3;

    localparam logic MST1 = 1'b0;
    localparam logic MST2 = 1'b1;

    localparam int TIMEOUT_DEFAULT = 63;

    // One-hot slave enable for a slave id; SLV_NONE decodes to no enable.
    function automatic logic [2:0] slave_onehot(slave_id_t s);
        logic [2:0] oh;
        oh = 3'b000;
        if (s != SLV_NONE) oh[s] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter handshake bundle: master requests, slave split flags, grants and selects.
// The master modport is the requesting side; the slave modport is the arbiter.
interface bus_arbiter_if;
    import bus_arb_pkg::*;

    logic       m1_req;
    slave_id_t  m1_slave_sel;
    logic       m1_done;
    logic       m2_req;
    slave_id_t  m2_slave_sel;
    logic       m2_done;
    logic [2:0] split_en;

    logic       m1_grant;
    logic       m2_grant;
    logic       msel;
    slave_id_t  ssel;
    logic [2:0] s_en;
    logic       split_pending;
    logic       timeout;

    modport master (
        output m1_req, m1_slave_sel, m1_done,
        output m2_req, m2_slave_sel, m2_done, split_en,
        input  m1_grant, m2_grant, msel, ssel, s_en, split_pending, timeout
    );

    modport slave (
        input  m1_req, m1_slave_sel, m1_done,
        input  m2_req, m2_slave_sel, m2_done, split_en,
        output m1_grant, m2_grant, msel, ssel, s_en, split_pending, timeout
    );

endinterface

// File: rtl/arb_timeout_counter.sv
// Ownership-age counter: counts cycles while a master holds the bus and
// flags when the count reaches the forced-release limit.
module arb_timeout_counter #(
    parameter int WIDTH   = 6,
    parameter int TIMEOUT = 63
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT);

    logic [WIDTH-1:0] cnt;

    // Clear dominates enable so every new owner starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
    end

    assign hit = (cnt == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Central bus arbiter: grants one of two masters, drives mux selects and
// slave enables, parks a master on a slave split and resumes it first.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    arb_state_t state;
    logic       m1_grant, m2_grant, msel, timeout;
    slave_id_t  ssel;
    logic [2:0] s_en;

    logic       split_valid;
    logic       split_master;
    slave_id_t  split_slave;

    logic       to_hit;
    logic       own_done, own_split, resume_ok, m1_ok, m2_ok;

    arb_timeout_counter #(.WIDTH(6), .TIMEOUT(TIMEOUT)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (state == IDLE),
        .en    (state != IDLE),
        .hit   (to_hit)
    );

    // Per-cycle decisions: owner done/split, resume of a parked master, and
    // request eligibility (valid slave, not the parked slave, not the parked master).
    always_comb begin
        own_done  = (state == M2_OWN) ? bus.m2_done : bus.m1_done;
        own_split = |(slave_onehot(ssel) & bus.split_en);
        resume_ok = split_valid && !(|(slave_onehot(split_slave) & bus.split_en));
        m1_ok     = bus.m1_req && (bus.m1_slave_sel != SLV_NONE)
                    && !(split_valid && bus.m1_slave_sel == split_slave)
                    && !(split_valid && split_master == MST1);
        m2_ok     = bus.m2_req && (bus.m2_slave_sel != SLV_NONE)
                    && !(split_valid && bus.m2_slave_sel == split_slave)
                    && !(split_valid && split_master == MST2);
    end

    // Arbitration FSM with registered outputs; msel holds the last owner while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            m1_grant     <= 1'b0;
            m2_grant     <= 1'b0;
            msel         <= MST1;
            ssel         <= SLV_NONE;
            s_en         <= 3'b000;
            timeout      <= 1'b0;
            split_valid  <= 1'b0;
            split_master <= MST1;
            split_slave  <= SLV_NONE;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (resume_ok) begin
                        split_valid <= 1'b0;
                        ssel        <= split_slave;
                        s_en        <= slave_onehot(split_slave);
                        msel        <= split_master;
                        if (split_master == MST1) begin
                            state    <= M1_OWN;
                            m1_grant <= 1'b1;
                        end else begin
                            state    <= M2_OWN;
                            m2_grant <= 1'b1;
                        end
                    end else if (m1_ok) begin
                        state    <= M1_OWN;
                        m1_grant <= 1'b1;
                        msel     <= MST1;
                        ssel     <= bus.m1_slave_sel;
                        s_en     <= slave_onehot(bus.m1_slave_sel);
                    end else if (m2_ok) begin
                        state    <= M2_OWN;
                        m2_grant <= 1'b1;
                        msel     <= MST2;
                        ssel     <= bus.m2_slave_sel;
                        s_en     <= slave_onehot(bus.m2_slave_sel);
                    end
                end
                M1_OWN, M2_OWN: begin
                    // done beats split and timeout; a second split is ignored.
                    if (own_done || (own_split && !split_valid) || to_hit) begin
                        state    <= IDLE;
                        m1_grant <= 1'b0;
                        m2_grant <= 1'b0;
                        ssel     <= SLV_NONE;
                        s_en     <= 3'b000;
                        if (!own_done && own_split && !split_valid) begin
                            split_valid  <= 1'b1;
                            split_master <= (state == M2_OWN) ? MST2 : MST1;
                            split_slave  <= ssel;
                        end else if (!own_done && to_hit) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    m1_grant <= 1'b0;
                    m2_grant <= 1'b0;
                    ssel     <= SLV_NONE;
                    s_en     <= 3'b000;
                end
            endcase
        end
    end

    assign bus.m1_grant      = m1_grant;
    assign bus.m2_grant      = m2_grant;
    assign bus.msel          = msel;
    assign bus.ssel          = ssel;
    assign bus.s_en          = s_en;
    assign bus.split_pending = split_valid;
    assign bus.timeout       = timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: constant vector table, directed
// split/timeout/reset sequences, and random traffic against a behavioural model.
module tb_bus_arbiter;

    localparam int TO = 63;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    bus_arbiter_if bif();

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    // Behavioural model: owner 0 = none, 1 = M1, 2 = M2; age = cycles owned.
    int mo, mssel, mmsel, mage, msv, msm, mss, mto;

    typedef struct {
        logic       m1_req;
        logic [1:0] m1_sel;
        logic       m1_done;
        logic       m2_req;
        logic [1:0] m2_sel;
        logic       m2_done;
        logic [2:0] split;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic r1, logic [1:0] s1, logic d1,
                                logic r2, logic [1:0] s2, logic d2, logic [2:0] sp,
                                logic g1, logic g2, logic ms, logic [1:0] ss,
                                logic [2:0] se, logic pend, logic tmo);
        vec_t v;
        v.m1_req = r1; v.m1_sel = s1; v.m1_done = d1;
        v.m2_req = r2; v.m2_sel = s2; v.m2_done = d2; v.split = sp;
        v.exp = {g1, g2, ms, ss, se, pend, tmo};
        return v;
    endfunction

    function automatic logic [9:0] act_v();
        return {bif.m1_grant, bif.m2_grant, bif.msel, bif.ssel, bif.s_en,
                bif.split_pending, bif.timeout};
    endfunction

    function automatic logic [9:0] exp_v();
        logic [2:0] se;
        se = (mssel == 3) ? 3'b000 : 3'(1 << mssel);
        return {mo == 1, mo == 2, mmsel[0], 2'(mssel), se, msv != 0, mto != 0};
    endfunction

    task automatic check(string nm, logic [15:0] a, logic [15:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        mo = 0; mssel = 3; mmsel = 0; mage = 0; msv = 0; msm = 1; mss = 3; mto = 0;
    endtask

    function automatic bit req_ok(int m);
        logic r;
        int   s;
        r = (m == 1) ? bif.m1_req : bif.m2_req;
        s = (m == 1) ? int'(bif.m1_slave_sel) : int'(bif.m2_slave_sel);
        return r && s != 3 && !(msv != 0 && (s == mss || msm == m));
    endfunction

    // Applies the arbitration rules to the inputs present at this edge.
    task automatic model_step();
        logic done;
        mto = 0;
        if (mo == 0) begin
            if (msv != 0 && !bif.split_en[mss]) begin
                mo = msm; mssel = mss; msv = 0;
            end else if (req_ok(1)) begin
                mo = 1; mssel = int'(bif.m1_slave_sel);
            end else if (req_ok(2)) begin
                mo = 2; mssel = int'(bif.m2_slave_sel);
            end
            mage = 0;
        end else begin
            done = (mo == 1) ? bif.m1_done : bif.m2_done;
            mage++;
            if (done) begin
                mo = 0; mssel = 3;
            end else if (bif.split_en[mssel] && msv == 0) begin
                msv = 1; msm = mo; mss = mssel; mo = 0; mssel = 3;
            end else if (mage == TO + 1) begin
                mo = 0; mssel = 3; mto = 1;
            end
        end
        if (mo != 0) mmsel = mo - 1;
    endtask

    task automatic tick(string nm);
        @(posedge clk);
        model_step();
        #1;
        check(nm, 16'(act_v()), 16'(exp_v()));
        check({nm, "_excl"}, 16'(bif.m1_grant & bif.m2_grant), 16'd0);
    endtask

    task automatic clear_inputs();
        bif.m1_req = 0; bif.m1_slave_sel = 0; bif.m1_done = 0;
        bif.m2_req = 0; bif.m2_slave_sel = 0; bif.m2_done = 0; bif.split_en = 0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("reset_vals", 16'(act_v()), 16'(10'b0001100000));
        clear_inputs();
        #2 reset = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(1,1,0, 0,0,0, 3'b000,  1,0,0,1,3'b010,0,0);
        tbl[1]  = mk(0,0,0, 0,0,0, 3'b000,  1,0,0,1,3'b010,0,0);
        tbl[2]  = mk(0,0,1, 0,0,0, 3'b000,  0,0,0,3,3'b000,0,0);
        tbl[3]  = mk(1,0,0, 1,2,0, 3'b000,  1,0,0,0,3'b001,0,0);
        tbl[4]  = mk(0,0,1, 1,2,0, 3'b000,  0,0,0,3,3'b000,0,0);
        tbl[5]  = mk(0,0,0, 1,2,0, 3'b000,  0,1,1,2,3'b100,0,0);
        tbl[6]  = mk(0,0,0, 0,0,1, 3'b000,  0,0,1,3,3'b000,0,0);
        tbl[7]  = mk(1,3,0, 0,0,0, 3'b000,  0,0,1,3,3'b000,0,0);
        tbl[8]  = mk(1,1,0, 0,0,0, 3'b000,  1,0,0,1,3'b010,0,0);
        tbl[9]  = mk(0,0,1, 0,0,0, 3'b010,  0,0,0,3,3'b000,0,0);
        tbl[10] = mk(0,0,0, 0,0,0, 3'b010,  0,0,0,3,3'b000,0,0);
        tbl[11] = mk(0,0,0, 1,3,1, 3'b000,  0,0,0,3,3'b000,0,0);

        clear_inputs();
        model_reset();
        #12;
        check("reset_init", 16'(act_v()), 16'(10'b0001100000));
        reset = 1'b1;

        // Vector table: single grants, M1-over-M2 priority, turnaround, done+split.
        for (int i = 0; i < 12; i++) begin
            bif.m1_req = tbl[i].m1_req; bif.m1_slave_sel = tbl[i].m1_sel;
            bif.m1_done = tbl[i].m1_done;
            bif.m2_req = tbl[i].m2_req; bif.m2_slave_sel = tbl[i].m2_sel;
            bif.m2_done = tbl[i].m2_done; bif.split_en = tbl[i].split;
            tick($sformatf("tbl%0d_model", i));
            check($sformatf("tbl%0d", i), 16'(act_v()), 16'(tbl[i].exp));
        end

        // Split: park M1 on slave 2, lend bus to M2, resume M1 with priority.
        do_reset();
        bif.m1_req = 1; bif.m1_slave_sel = 2;
        tick("sp_req");
        check("sp_grant", 16'({bif.m1_grant, bif.ssel}), 16'({1'b1, 2'd2}));
        bif.m1_req = 0; bif.split_en = 3'b100;
        tick("sp_split");
        check("sp_park", 16'({bif.m1_grant, bif.split_pending}), 16'(2'b01));
        bif.m2_req = 1; bif.m2_slave_sel = 2; bif.m1_req = 1; bif.m1_slave_sel = 0;
        tick("sp_d1");
        tick("sp_d2");
        check("sp_defer", 16'({bif.m1_grant, bif.m2_grant}), 16'd0);
        bif.m2_slave_sel = 0; bif.m1_req = 0;
        tick("sp_l");
        check("sp_lend", 16'({bif.m2_grant, bif.ssel}), 16'({1'b1, 2'd0}));
        bif.split_en = 3'b000;
        tick("sp_own");
        bif.m2_done = 1;
        tick("sp_m2done");
        bif.m2_done = 0;
        tick("sp_r");
        check("sp_resume", 16'({bif.m1_grant, bif.m2_grant, bif.ssel, bif.split_pending}),
              16'({1'b1, 1'b0, 2'd2, 1'b0}));

        // Reset while a split is parked and M2 owns the bus.
        bif.m2_req = 0; bif.split_en = 3'b100;
        tick("rs_park");
        bif.m2_req = 1; bif.m2_slave_sel = 0;
        tick("rs_m2");
        check("rs_pre", 16'({bif.m2_grant, bif.split_pending}), 16'(2'b11));
        do_reset();
        bif.m1_req = 1; bif.m1_slave_sel = 1;
        tick("rs_after");
        check("rs_regrant", 16'({bif.m1_grant, bif.ssel}), 16'({1'b1, 2'd1}));

        // Timeout: M2 holds slave 0 without done.
        do_reset();
        bif.m2_req = 1; bif.m2_slave_sel = 0;
        tick("to_grant");
        bif.m2_req = 0;
        for (int i = 0; i < TO; i++) tick("to_hold");
        check("to_held", 16'(bif.m2_grant), 16'd1);
        tick("to_fire");
        check("to_pulse", 16'({bif.m2_grant, bif.timeout}), 16'(2'b01));
        tick("to_after");
        check("to_oneshot", 16'(bif.timeout), 16'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bif.m1_req = 1'($urandom_range(0, 1));
            bif.m1_slave_sel = 2'($urandom_range(0, 3));
            bif.m1_done = ($urandom_range(0, 7) == 0);
            bif.m2_req = 1'($urandom_range(0, 1));
            bif.m2_slave_sel = 2'($urandom_range(0, 3));
            bif.m2_done = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) bif.split_en = 3'($urandom_range(0, 7));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
